line_fetch: RTL and testbench
=============================

LINE_FETCH -- requirements
Module: line_fetch

Interface
REQ-001 SHALL provide parameter MAXW, default 80, the maximum words per line and the depth of each line-buffer bank.
REQ-002 SHALL provide ports, in this order:
- dotclk_i  in  1  dot clock; all state changes on its rising edge.
- reset_i  in  1  asynchronous, active-low reset.
- hden_i  in  1  CRTC horizontal display enable.
- vden_i  in  1  CRTC vertical display enable.
- vfen_i  in  1  CRTC vertical fetch enable, asserted one line before vden_i.
- vsync_i  in  1  CRTC vertical sync.
- fbbase_i  in  24  frame-buffer base word address.
- wpl_i  in  7  words per line.
- cyc_o  out  1  bus cycle.
- stb_o  out  1  bus strobe.
- adr_o  out  24  word address.
- dat_i  in  16  read data.
- ack_i  in  1  read acknowledge.
- pixel_o  out  1  registered monochrome pixel.
- underrun_o  out  1  sticky fetch-underrun flag.

Function
REQ-003 Line start SHALL be the cycle with hden_i=1 and the registered previous hden_i=0; frame start SHALL be the cycle with vsync_i=1 and the registered previous vsync_i=0.
REQ-004 Storage SHALL be two banks of MAXW x 16 bits, each with a valid-word count; the display bank select (dsel) SHALL toggle at every line start, and the fill bank SHALL always be ~dsel.
REQ-005 At line start, the new fill bank's valid count SHALL clear to 0.
REQ-006 At line start with vfen_i=1 and effective wpl>0, the fetch FSM SHALL enter FETCH with remaining = effective wpl; effective wpl = min(wpl_i, MAXW), sampled at line start.
REQ-007 Fetch FSM states: IDLE and FETCH.
- cyc_o and stb_o SHALL be 1 exactly while in FETCH.
- adr_o SHALL hold the address pointer and stay stable until ack_i.
REQ-008 Each cycle in FETCH with ack_i=1:
- dat_i SHALL be written to fill bank word [valid count].
- Valid count SHALL increment, the address pointer SHALL increment (24-bit wrap), and remaining SHALL decrement.
- The FSM SHALL return to IDLE when remaining reaches 0.
- Back-to-back single-cycle acks SHALL be supported.
REQ-009 The address pointer SHALL load fbbase_i at frame start and otherwise persist across lines, so consecutive lines are contiguous.
REQ-010 Frame start during FETCH SHALL abort the fetch: FSM to IDLE, pointer reloaded, underrun_o unaffected.
REQ-011 Frame start coinciding with line start SHALL reload the pointer first, so that line's fetch begins at fbbase_i.
REQ-012 Line start while in FETCH (underrun) SHALL:
- set underrun_o=1;
- abort the old fetch;
- swap banks;
- start a new fetch per REQ-006.
REQ-013 On cycles with hden_i=1 and vden_i=1, pixel_o SHALL load bit (15 - bit index) of display-bank word [word index], MSB first.
- Both indexes SHALL clear at line start, and the line-start cycle SHALL use the newly selected bank and produce bit 15 of word 0.
- The bit index SHALL wrap 15->0 while incrementing the word index.
REQ-014 A word index >= the display bank's valid count SHALL yield pixel_o=0.
REQ-015 On any cycle with hden_i=0 or vden_i=0, pixel_o SHALL load 0.
REQ-016 Latency: pixel_o SHALL reflect the pixel selected in cycle n at cycle n+1.
REQ-017 wpl_i=0 SHALL cause no bus activity, and that line SHALL display all zeros.
REQ-018 underrun_o SHALL remain 1 until reset.

Reset
REQ-019 While reset_i=0, state SHALL reset asynchronously:
- FSM IDLE; cyc_o, stb_o, pixel_o, underrun_o = 0.
- adr_o=0; dsel=0; both valid counts 0.
- All indexes and edge-detect registers 0.
REQ-020 Reset asserted during FETCH SHALL drop cyc_o and stb_o immediately, without waiting for ack_i.

Verification
REQ-021 Basic fetch: fbbase_i=0x001000, wpl_i=2, vsync rise, then line start with vfen_i=1; ack every cycle with 0xA5A5, 0xFFFF -> adr_o 0x001000 then 0x001001, cyc_o low after the second ack.
REQ-022 Display of basic fetch: next line start with vden_i=1 and 40 hden_i cycles -> pixel_o = 1010010110100101, then 16 ones, then 8 zeros, each one clock delayed.
REQ-023 Contiguity: a second fetched line -> first adr_o=0x001002; a vsync rise during that fetch -> cyc_o=0 next cycle, underrun_o=0, and the next fetch begins at 0x001000.
REQ-024 Underrun: wpl_i=4, ack only twice before the next line start -> underrun_o=1, and the displayed line shows the 2 words followed by zeros.
REQ-025 Boundaries: wpl_i=0 -> cyc_o never asserts and pixel_o=0 all line; wpl_i=100 -> exactly 80 acks are consumed.
REQ-026 Mid-fetch reset: reset_i low mid-FETCH -> cyc_o, stb_o, adr_o, pixel_o all 0 with no clock edge required.

Source files
------------

// File: rtl/line_fetch.sv
// Double-buffered scan-line fetcher: bursts one line of frame-buffer words into the fill bank
// while the display bank is shifted out MSB-first as a monochrome pixel stream.
module line_fetch #(
  parameter int MAXW = 80
) (
  input  logic        dotclk_i,
  input  logic        reset_i,
  input  logic        hden_i,
  input  logic        vden_i,
  input  logic        vfen_i,
  input  logic        vsync_i,
  input  logic [23:0] fbbase_i,
  input  logic [6:0]  wpl_i,
  output logic        cyc_o,
  output logic        stb_o,
  output logic [23:0] adr_o,
  input  logic [15:0] dat_i,
  input  logic        ack_i,
  output logic        pixel_o,
  output logic        underrun_o
);

  localparam int CW = $clog2(MAXW + 1);
  localparam int AW = (MAXW > 1) ? $clog2(MAXW) : 1;

  typedef enum logic {IDLE, FETCH} state_e;

  state_e               state_q, state_d;
  logic                 hden_q, vsync_q;
  logic                 dsel_q, dsel_d;
  logic [1:0][CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]        rem_q, rem_d;
  logic [23:0]          adr_q, adr_d;
  logic [CW-1:0]        word_q, word_d;
  logic [3:0]           bit_q, bit_d;
  logic                 pixel_q, pixel_d;
  logic                 underrun_q, underrun_d;

  logic [15:0]          mem [2][MAXW];
  logic                 wr_en;
  logic                 wr_bank;
  logic [AW-1:0]        wr_addr;

  logic                 line_start, frame_start;
  logic [CW-1:0]        eff_wpl;
  logic                 disp_bank;
  logic [CW-1:0]        cur_word;
  logic [3:0]           cur_bit;
  logic [15:0]          rd_word;

  assign line_start  = hden_i & ~hden_q;
  assign frame_start = vsync_i & ~vsync_q;

  always_comb begin
    state_d    = state_q;
    dsel_d     = dsel_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    adr_d      = adr_q;
    word_d     = word_q;
    bit_d      = bit_q;
    pixel_d    = 1'b0;
    underrun_d = underrun_q;
    wr_en      = 1'b0;
    wr_bank    = ~dsel_q;
    wr_addr    = AW'(cnt_q[~dsel_q]);
    rd_word    = 16'h0000;

    if (int'(wpl_i) > MAXW) eff_wpl = CW'(MAXW);
    else                    eff_wpl = CW'(wpl_i);

    if (frame_start) adr_d = fbbase_i;

    // Line start wins over everything: an ack landing on that cycle belongs to an aborted fetch.
    if (line_start) begin
      dsel_d         = ~dsel_q;
      cnt_d[dsel_q]  = '0;
      if (state_q == FETCH) underrun_d = 1'b1;
      if (vfen_i && eff_wpl != '0) begin
        state_d = FETCH;
        rem_d   = eff_wpl;
      end else begin
        state_d = IDLE;
      end
    end else if (frame_start) begin
      state_d = IDLE;
    end else if (state_q == FETCH && ack_i) begin
      wr_en           = 1'b1;
      cnt_d[~dsel_q]  = cnt_q[~dsel_q] + 1'b1;
      adr_d           = adr_q + 24'd1;
      rem_d           = rem_q - 1'b1;
      if (rem_q == CW'(1)) state_d = IDLE;
    end

    disp_bank = line_start ? ~dsel_q : dsel_q;
    cur_word  = line_start ? '0 : word_q;
    cur_bit   = line_start ? 4'd0 : bit_q;
    if (line_start) begin
      word_d = '0;
      bit_d  = 4'd0;
    end

    if (hden_i && vden_i) begin
      if (cur_word < cnt_q[disp_bank]) begin
        rd_word = mem[disp_bank][AW'(cur_word)];
        pixel_d = rd_word[4'd15 - cur_bit];
      end
      // Word index saturates at MAXW, which is always past the valid count.
      if (cur_bit == 4'd15) begin
        bit_d  = 4'd0;
        word_d = (cur_word == CW'(MAXW)) ? cur_word : cur_word + 1'b1;
      end else begin
        bit_d  = cur_bit + 4'd1;
        word_d = cur_word;
      end
    end
  end

  always_ff @(posedge dotclk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q    <= IDLE;
      hden_q     <= 1'b0;
      vsync_q    <= 1'b0;
      dsel_q     <= 1'b0;
      cnt_q      <= '0;
      rem_q      <= '0;
      adr_q      <= 24'h000000;
      word_q     <= '0;
      bit_q      <= 4'd0;
      pixel_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      hden_q     <= hden_i;
      vsync_q    <= vsync_i;
      dsel_q     <= dsel_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      adr_q      <= adr_d;
      word_q     <= word_d;
      bit_q      <= bit_d;
      pixel_q    <= pixel_d;
      underrun_q <= underrun_d;
    end
  end

  always_ff @(posedge dotclk_i) begin
    if (wr_en) mem[wr_bank][wr_addr] <= dat_i;
  end

  assign cyc_o      = (state_q == FETCH);
  assign stb_o      = (state_q == FETCH);
  assign adr_o      = adr_q;
  assign pixel_o    = pixel_q;
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_line_fetch.sv
// Directed bench for line_fetch: drives whole scan lines with scripted acks and checks
// bus activity, addresses, underrun and the pixel stream against hand-derived values.
module tb_line_fetch;

  logic        dotclk = 1'b0;
  logic        reset_n;
  logic        hden, vden, vfen, vsync;
  logic [23:0] fbbase;
  logic [6:0]  wpl;
  logic        cyc, stb;
  logic [23:0] adr;
  logic [15:0] dat;
  logic        ack;
  logic        pixel, underrun;

  int          numChecks = 0;
  int          numFails  = 0;

  logic [15:0] dispWords [0:79];
  int          dispCnt;
  logic [15:0] ackData [0:127];
  logic        cycObs [0:127];
  logic [23:0] adrObs [0:127];
  logic        undObs [0:127];
  int          acceptedCnt;
  int          cycOnes;

  line_fetch #(.MAXW(80)) dut (
    .dotclk_i   (dotclk),
    .reset_i    (reset_n),
    .hden_i     (hden),
    .vden_i     (vden),
    .vfen_i     (vfen),
    .vsync_i    (vsync),
    .fbbase_i   (fbbase),
    .wpl_i      (wpl),
    .cyc_o      (cyc),
    .stb_o      (stb),
    .adr_o      (adr),
    .dat_i      (dat),
    .ack_i      (ack),
    .pixel_o    (pixel),
    .underrun_o (underrun)
  );

  always #5 dotclk = ~dotclk;

  task automatic tick();
    @(posedge dotclk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    numChecks++;
    if (obs !== exp) begin
      numFails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One scan line of n hden cycles, acks offered on cycles ackFrom..ackTo, vsync pulsed at vsAt.
  task automatic applyStimulus(input string name, input int n, input bit vd, input bit vf,
                               input logic [6:0] w, input int ackFrom, input int ackTo,
                               input int vsAt);
    logic       expPix;
    logic       cycPre;
    logic [15:0] word;
    acceptedCnt = 0;
    cycOnes     = 0;
    for (int k = 0; k < n; k++) begin
      hden  = 1'b1;
      vden  = vd;
      vfen  = vf;
      wpl   = w;
      vsync = (k == vsAt);
      ack   = (k >= ackFrom && k <= ackTo);
      dat   = ack ? ackData[k - ackFrom] : 16'h0000;
      cycPre = cyc;
      if (ack && cycPre && k != 0) acceptedCnt++;
      tick();
      cycObs[k] = cyc;
      adrObs[k] = adr;
      undObs[k] = underrun;
      if (cyc) cycOnes++;
      expPix = 1'b0;
      if (vd && (k / 16) < dispCnt) begin
        word   = dispWords[k / 16];
        expPix = word[15 - (k % 16)];
      end
      checkOutput($sformatf("%s pixel[%0d]", name, k), {31'd0, pixel}, {31'd0, expPix});
    end
    hden  = 1'b0;
    vsync = 1'b0;
    ack   = 1'b0;
    dat   = 16'h0000;
    tick();
    checkOutput($sformatf("%s blank pixel", name), {31'd0, pixel}, 32'd0);
    tick();
    tick();
  endtask

  initial begin
    reset_n = 1'b0;
    hden = 1'b0; vden = 1'b0; vfen = 1'b0; vsync = 1'b0;
    fbbase = 24'h001000; wpl = 7'd2; dat = 16'h0000; ack = 1'b0;
    dispCnt = 0;
    #3;
    checkOutput("reset cyc", {31'd0, cyc}, 32'd0);
    checkOutput("reset stb", {31'd0, stb}, 32'd0);
    checkOutput("reset adr", {8'd0, adr}, 32'd0);
    checkOutput("reset pixel", {31'd0, pixel}, 32'd0);
    checkOutput("reset underrun", {31'd0, underrun}, 32'd0);
    tick();
    reset_n = 1'b1;
    tick();

    // Frame start loads the base pointer.
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
    checkOutput("frame adr", {8'd0, adr}, 32'h001000);

    // Line A: basic two-word fetch, nothing displayed.
    ackData[0] = 16'hA5A5; ackData[1] = 16'hFFFF;
    applyStimulus("A", 24, 1'b0, 1'b1, 7'd2, 1, 2, -1);
    checkOutput("A cyc start", {31'd0, cycObs[0]}, 32'd1);
    checkOutput("A adr first", {8'd0, adrObs[0]}, 32'h001000);
    checkOutput("A cyc after ack1", {31'd0, cycObs[1]}, 32'd1);
    checkOutput("A adr second", {8'd0, adrObs[1]}, 32'h001001);
    checkOutput("A cyc done", {31'd0, cycObs[2]}, 32'd0);

    // Line B: display A's words; its own fetch is aborted by a vsync rise.
    dispWords[0] = 16'hA5A5; dispWords[1] = 16'hFFFF; dispCnt = 2;
    applyStimulus("B", 40, 1'b1, 1'b1, 7'd2, 200, 200, 1);
    checkOutput("B adr contiguous", {8'd0, adrObs[0]}, 32'h001002);
    checkOutput("B cyc start", {31'd0, cycObs[0]}, 32'd1);
    checkOutput("B cyc abort", {31'd0, cycObs[1]}, 32'd0);
    checkOutput("B adr reload", {8'd0, adrObs[1]}, 32'h001000);
    checkOutput("B underrun", {31'd0, undObs[39]}, 32'd0);

    // Line C: fetch restarts at the base after the abort.
    ackData[0] = 16'h8001; ackData[1] = 16'h7FFE;
    applyStimulus("C", 24, 1'b0, 1'b1, 7'd2, 1, 2, -1);
    checkOutput("C adr first", {8'd0, adrObs[0]}, 32'h001000);

    // Line D: show C's words; fetch four but only two acks arrive.
    dispWords[0] = 16'h8001; dispWords[1] = 16'h7FFE; dispCnt = 2;
    ackData[0] = 16'h1111; ackData[1] = 16'h2222;
    applyStimulus("D", 40, 1'b1, 1'b1, 7'd4, 1, 2, -1);
    checkOutput("D adr first", {8'd0, adrObs[0]}, 32'h001002);
    checkOutput("D still fetching", {31'd0, cycObs[39]}, 32'd1);
    checkOutput("D no underrun yet", {31'd0, undObs[39]}, 32'd0);

    // Line E: underrun line shows the two words that did arrive.
    dispWords[0] = 16'h1111; dispWords[1] = 16'h2222; dispCnt = 2;
    applyStimulus("E", 40, 1'b1, 1'b0, 7'd4, 200, 200, -1);
    checkOutput("E underrun set", {31'd0, undObs[0]}, 32'd1);
    checkOutput("E cyc aborted", {31'd0, cycObs[0]}, 32'd0);

    // Line F: zero words per line means no bus activity.
    applyStimulus("F", 24, 1'b0, 1'b1, 7'd0, 200, 200, -1);
    checkOutput("F cyc count", cycOnes, 32'd0);

    // Line G: F's empty bank displays as all zeros.
    dispCnt = 0;
    applyStimulus("G", 40, 1'b1, 1'b0, 7'd0, 200, 200, -1);

    // Line H: 100 words requested, clamped to 80.
    for (int i = 0; i < 128; i++) ackData[i] = 16'hFFFF;
    applyStimulus("H", 100, 1'b0, 1'b1, 7'd100, 1, 99, -1);
    checkOutput("H acks consumed", acceptedCnt, 32'd80);
    checkOutput("H cyc before last", {31'd0, cycObs[79]}, 32'd1);
    checkOutput("H cyc after last", {31'd0, cycObs[80]}, 32'd0);
    checkOutput("H adr end", {8'd0, adrObs[99]}, 32'h001054);
    checkOutput("H underrun sticky", {31'd0, undObs[99]}, 32'd1);

    // Line I: reset asynchronously in the middle of a fetch.
    hden = 1'b1; vden = 1'b1; vfen = 1'b1; wpl = 7'd2; ack = 1'b0;
    tick();
    checkOutput("I cyc before reset", {31'd0, cyc}, 32'd1);
    checkOutput("I pixel before reset", {31'd0, pixel}, 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("I cyc in reset", {31'd0, cyc}, 32'd0);
    checkOutput("I stb in reset", {31'd0, stb}, 32'd0);
    checkOutput("I adr in reset", {8'd0, adr}, 32'd0);
    checkOutput("I pixel in reset", {31'd0, pixel}, 32'd0);
    checkOutput("I underrun in reset", {31'd0, underrun}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", numChecks, numFails);
    $finish;
  end

endmodule
